// File: rtl/sdram_arb_pkg.sv
// Shared constants and types for the two-port SDRAM arbiter.
// State encoding, port count and bus widths live here so every file agrees.
package sdram_arb_pkg;
  localparam int NUM_PORTS = 2;
  localparam int ADDR_W    = 22;
  localparam int DATA_W    = 16;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } port_req_t;
endpackage

// File: rtl/sdram_arb_port.sv
// One client port: bundles the incoming request and owns that port's
// registered ack pulse and read-data holding register.
module sdram_arb_port
  import sdram_arb_pkg::*;
(
  input  logic              clk50mhz,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_done,
  input  logic              i_is_read,
  input  logic [DATA_W-1:0] i_sd_odata,
  output port_req_t         o_req,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata
);
  logic              r_ack;
  logic [DATA_W-1:0] r_rdata;

  assign o_req   = '{req: i_req, wr: i_wr, addr: i_addr, wdata: i_wdata};
  assign o_ack   = r_ack;
  assign o_rdata = r_rdata;

  // i_done marks this port's last ACCESS cycle, so the ack lands one cycle later
  // together with the freshly captured read data.
  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= i_done;
      if (i_done && i_is_read) r_rdata <= i_sd_odata;
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter: IDLE -> ACCESS (strobe held) -> GAP (strobes idle).
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority to port 0.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 12,
  parameter int GAP_CYCLES    = 4
) (
  input  logic              clk50mhz,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_wdata,
  output logic              sd_rd,
  output logic              sd_we_n,
  input  logic [DATA_W-1:0] sd_odata,
  output arb_state_e        o_dbg_state
);
  // Handshake: a client raises req with wr/addr/wdata valid and holds them until
  // its one-cycle ack; the request is latched at grant, so later changes are ignored.
  localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

  arb_state_e        r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_idx;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  port_req_t         w_req [NUM_PORTS];
  port_req_t         w_win;
  logic              w_any_req, w_grant_idx, w_prefer_p1, w_start, w_done;

  sdram_arb_port u_port0 (
    .clk50mhz   (clk50mhz),
    .reset      (reset),
    .i_req      (p0_req),
    .i_wr       (p0_wr),
    .i_addr     (p0_addr),
    .i_wdata    (p0_wdata),
    .i_done     (w_done && !r_idx),
    .i_is_read  (!r_wr),
    .i_sd_odata (sd_odata),
    .o_req      (w_req[0]),
    .o_ack      (p0_ack),
    .o_rdata    (p0_rdata)
  );

  sdram_arb_port u_port1 (
    .clk50mhz   (clk50mhz),
    .reset      (reset),
    .i_req      (p1_req),
    .i_wr       (p1_wr),
    .i_addr     (p1_addr),
    .i_wdata    (p1_wdata),
    .i_done     (w_done && r_idx),
    .i_is_read  (!r_wr),
    .i_sd_odata (sd_odata),
    .o_req      (w_req[1]),
    .o_ack      (p1_ack),
    .o_rdata    (p1_rdata)
  );

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic r_last_grant;
  assign w_prefer_p1 = !r_last_grant;

  always_ff @(posedge clk50mhz) begin
    if (reset)        r_last_grant <= 1'b1;
    else if (w_start) r_last_grant <= w_grant_idx;
  end
`else
  assign w_prefer_p1 = 1'b0;
`endif

  assign w_any_req   = w_req[0].req || w_req[1].req;
  assign w_grant_idx = w_req[1].req && (!w_req[0].req || w_prefer_p1);

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_win        = w_grant_idx ? w_req[1] : w_req[0];
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_next_state = ST_ACCESS;
          w_start      = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == '0) begin
          w_next_state = ST_GAP;
          w_done       = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // The counter reloads on entry to ACCESS/GAP and parks at zero otherwise.
  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_cnt   <= ACCESS_LOAD;
        r_idx   <= w_grant_idx;
        r_wr    <= w_win.wr;
        r_addr  <= w_win.addr;
        r_wdata <= w_win.wdata;
      end else if (w_done) begin
        r_cnt <= GAP_LOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign sd_rd       = (r_state == ST_ACCESS) && !r_wr;
  assign sd_we_n     = !((r_state == ST_ACCESS) && r_wr);
  assign sd_addr     = r_addr;
  assign sd_wdata    = r_wdata;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small SDRAM controller model.
// Build with or without SDRAM_ARB_ROUND_ROBIN_EN; arbitration expectations follow the macro.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int ACC = 12;
  localparam int GAP = 4;

  logic        clk50mhz, reset;
  logic        p0_req, p0_wr, p1_req, p1_wr;
  logic [21:0] p0_addr, p1_addr, sd_addr;
  logic [15:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, sd_wdata, sd_odata;
  logic        p0_ack, p1_ack, sd_rd, sd_we_n;
  arb_state_e  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  sdram_arbiter #(.ACCESS_CYCLES(ACC), .GAP_CYCLES(GAP)) dut (
    .clk50mhz(clk50mhz), .reset(reset),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .sd_addr(sd_addr), .sd_wdata(sd_wdata), .sd_rd(sd_rd), .sd_we_n(sd_we_n),
    .sd_odata(sd_odata), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk50mhz = 1'b0;
  always #10 clk50mhz = ~clk50mhz;

  // ---------------- controller model ----------------
  logic [15:0] mem [logic [21:0]];
  logic prev_rd = 1'b0;
  logic prev_we_n = 1'b1;
  int cyc = 0;
  int refresh_until = 0;
  int rd_detect = 0;
  int wr_detect = 0;
  int missed = 0;
  int viol = 0;

  function automatic logic [15:0] model_read(input logic [21:0] a);
    if (mem.exists(a)) return mem[a];
    return (a == 22'h000123) ? 16'hBEEF : 16'h0000;
  endfunction

  always @(posedge clk50mhz) begin
    cyc <= cyc + 1;
    if (sd_rd === 1'b1 && prev_rd !== 1'b1) begin
      if (cyc < refresh_until) missed <= missed + 1;
      else begin
        rd_detect <= rd_detect + 1;
        sd_odata  <= model_read(sd_addr);
      end
    end
    if (sd_we_n === 1'b0 && prev_we_n !== 1'b0) begin
      if (cyc < refresh_until) missed <= missed + 1;
      else begin
        wr_detect     <= wr_detect + 1;
        mem[sd_addr]   = sd_wdata;
      end
    end
    if (p0_ack === 1'b1 && p1_ack === 1'b1) viol <= viol + 1;
    if (sd_rd === 1'b1 && sd_we_n === 1'b0) viol <= viol + 1;
    prev_rd   <= sd_rd;
    prev_we_n <= sd_we_n;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk50mhz);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic req, input logic wr,
                       input logic [21:0] addr, input logic [15:0] wdata);
    if (p) begin p1_req = req; p1_wr = wr; p1_addr = addr; p1_wdata = wdata; end
    else   begin p0_req = req; p0_wr = wr; p0_addr = addr; p0_wdata = wdata; end
  endtask

  task automatic set_req(input logic p, input logic v);
    if (p) p1_req = v; else p0_req = v;
  endtask

  function automatic logic ack_of(input logic p);
    return p ? p1_ack : p0_ack;
  endfunction

  function automatic logic [15:0] rdata_of(input logic p);
    return p ? p1_rdata : p0_rdata;
  endfunction

  // Single transaction on an otherwise idle arbiter, observed for 20 cycles.
  task automatic run_txn(input string tag, input logic p, input logic wr,
                         input logic [21:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rdata);
    int ack_at = -1;
    int acks = 0, other = 0, strobe = 0, wrong = 0, bad_bus = 0;
    logic [15:0] rd_at_ack = 16'hxxxx;
    drive(p, 1'b1, wr, addr, wdata);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (wr ? (sd_we_n == 1'b0) : (sd_rd == 1'b1)) begin
        strobe++;
        if (sd_addr !== addr || (wr && sd_wdata !== wdata)) bad_bus++;
      end
      if (wr ? (sd_rd == 1'b1) : (sd_we_n == 1'b0)) wrong++;
      if (ack_of(!p)) other++;
      if (ack_of(p)) begin
        acks++;
        if (ack_at < 0) begin
          ack_at    = c;
          rd_at_ack = rdata_of(p);
          set_req(p, 1'b0);
        end
      end
    end
    check({tag, "_ack_latency"}, ack_at, ACC + 1);
    check({tag, "_ack_count"}, acks, 1);
    check({tag, "_other_ack"}, other, 0);
    check({tag, "_strobe_len"}, strobe, ACC);
    check({tag, "_wrong_strobe"}, wrong, 0);
    check({tag, "_bus_stable"}, bad_bus, 0);
    check({tag, "_rdata"}, rd_at_ack, exp_rdata);
    check({tag, "_idle"}, dbg_state, ST_IDLE);
  endtask

  typedef struct {
    logic        port;
    logic        wr;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   n_acks, last_ack, ack_at, rd0, miss0, slen, run;
    logic prev_s, s, have_prior, got;

    vecs[0] = '{1'b0, 1'b0, 22'h000123, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 22'h3FFFFF, 16'h1234, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 22'h3FFFFF, 16'h0000, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 22'h000000, 16'hA5A5, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b0, 22'h000000, 16'h0000, 16'hA5A5};
    vecs[5] = '{1'b1, 1'b0, 22'h000123, 16'h0000, 16'hBEEF};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 22'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 22'h0, 16'h0);
    repeat (3) tick();

    check("rst_state", dbg_state, ST_IDLE);
    check("rst_sd_rd", sd_rd, 1'b0);
    check("rst_sd_we_n", sd_we_n, 1'b1);
    check("rst_acks", {p0_ack, p1_ack}, 2'b00);
    check("rst_sd_addr", sd_addr, 22'h0);
    check("rst_sd_wdata", sd_wdata, 16'h0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("v%0d", i), vecs[i].port, vecs[i].wr, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_rdata);

    // Both ports requesting continuously.
    exp_q.delete();
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    exp_q = '{16'd0, 16'd1, 16'd0, 16'd1};
`else
    exp_q = '{16'd0, 16'd0, 16'd0, 16'd0};
`endif
    drive(1'b0, 1'b1, 1'b0, 22'h000123, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 22'h3FFFFF, 16'h0);
    n_acks = 0;
    last_ack = -1;
    for (int c = 1; c <= 120 && n_acks < 4; c++) begin
      tick();
      if (p0_ack || p1_ack) begin
        if (exp_q.size() > 0) check("arb_order", {15'd0, p1_ack}, exp_q.pop_front());
        check("arb_rdata", p1_ack ? p1_rdata : p0_rdata, p1_ack ? 16'h1234 : 16'hBEEF);
        if (last_ack >= 0) check("arb_spacing", c - last_ack, ACC + GAP + 1);
        else check("arb_first", c, ACC + 1);
        last_ack = c;
        n_acks++;
        if (n_acks == 4) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
          p0_req = 1'b0;
          p1_req = 1'b0;
`else
          p0_req = 1'b0;
`endif
        end
      end
    end
    check("arb_ack_total", n_acks, 4);
`ifndef SDRAM_ARB_ROUND_ROBIN_EN
    got = 1'b0;
    for (int c = 1; c <= 25 && !got; c++) begin
      tick();
      if (p1_ack) begin
        got = 1'b1;
        check("arb_loser_latency", c, ACC + GAP + 1);
        check("arb_loser_rdata", p1_rdata, 16'h1234);
        p1_req = 1'b0;
      end
    end
    check("arb_loser_served", got, 1'b1);
`endif
    repeat (20) tick();

    // Back-to-back p0 writes 0x0001..0x0004.
    exp_q.delete();
    for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i));
    drive(1'b0, 1'b1, 1'b1, 22'h000010, 16'h0001);
    n_acks = 0; last_ack = -1; slen = 0; run = 0;
    prev_s = 1'b0; have_prior = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      s = (sd_we_n == 1'b0);
      if (s && !prev_s) begin
        if (have_prior) check("b2b_gap", run, GAP + 1);
        if (exp_q.size() > 0) check("b2b_wdata", sd_wdata, exp_q.pop_front());
        else check("b2b_extra_write", sd_wdata, 16'hxxxx);
        slen = 0;
      end
      if (s) slen++;
      if (!s) begin
        if (prev_s) begin
          check("b2b_len", slen, ACC);
          run = 0;
          have_prior = 1'b1;
        end
        if (have_prior) run++;
      end
      prev_s = s;
      if (p0_ack) begin
        n_acks++;
        if (last_ack >= 0) check("b2b_ack_spacing", c - last_ack, ACC + GAP + 1);
        last_ack = c;
        if (n_acks < 4) drive(1'b0, 1'b1, 1'b1, 22'h000010 + 22'(n_acks), 16'(n_acks + 1));
        else p0_req = 1'b0;
      end
    end
    check("b2b_ack_total", n_acks, 4);
    check("b2b_queue_empty", exp_q.size(), 0);

    // Refresh injected in the GAP after a write; the following read must still be seen.
    drive(1'b1, 1'b1, 1'b1, 22'h02AAAA, 16'h0F0F);
    got = 1'b0;
    rd0 = 0; miss0 = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      tick();
      if (p1_ack) begin
        got = 1'b1;
        p1_req = 1'b0;
        refresh_until = cyc + 4;
        rd0 = rd_detect;
        miss0 = missed;
        drive(1'b0, 1'b1, 1'b0, 22'h02AAAA, 16'h0);
      end
    end
    check("ref_write_ack", got, 1'b1);
    got = 1'b0;
    for (int c = 1; c <= 30 && !got; c++) begin
      tick();
      if (p0_ack) begin
        got = 1'b1;
        p0_req = 1'b0;
        check("ref_rdata", p0_rdata, 16'h0F0F);
      end
    end
    check("ref_read_ack", got, 1'b1);
    check("ref_rd_detected", rd_detect - rd0, 1);
    check("ref_no_missed", missed - miss0, 0);
    repeat (5) tick();

    // Reset on the 5th ACCESS cycle of a p0 read, with the request kept pending.
    drive(1'b0, 1'b1, 1'b0, 22'h000123, 16'h0);
    rd0 = 0;
    for (int c = 1; c <= 30 && rd0 < 5; c++) begin
      tick();
      if (sd_rd) rd0++;
    end
    check("rst5_reached", rd0, 5);
    reset = 1'b1;
    tick();
    check("rst5_sd_rd", sd_rd, 1'b0);
    check("rst5_no_ack", p0_ack, 1'b0);
    check("rst5_state", dbg_state, ST_IDLE);
    check("rst5_rdata_clr", p0_rdata, 16'h0);
    reset = 1'b0;
    ack_at = -1; n_acks = 0; slen = 0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (sd_rd) slen++;
      if (p0_ack) begin
        n_acks++;
        if (ack_at < 0) begin
          ack_at = c;
          check("rst5_restart_rdata", p0_rdata, 16'hBEEF);
          p0_req = 1'b0;
        end
      end
    end
    check("rst5_restart_latency", ack_at, ACC + 1);
    check("rst5_restart_acks", n_acks, 1);
    check("rst5_restart_strobe", slen, ACC);

    check("no_overlap", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
